// File: rtl/i2c_pkg.sv
// Shared types and helpers for the byte-level I2C master used by the RTC controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    SLA_W,
    ADDR_H,
    ADDR_L,
    WR_DATA,
    RESTART,
    SLA_R,
    RD_DATA,
    STOP,
    DONE
  } i2c_state_t;

  // Quarter of an SCL bit period.
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } q_phase_t;

  function automatic int div_calc(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_dri_if.sv
// Command/response handshake between the RTC control FSM (master) and the I2C driver (slave).
interface i2c_dri_if;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (
    output i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w,
    input  i2c_data_r, i2c_done, i2c_ack
  );

  modport slave (
    input  i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w,
    output i2c_data_r, i2c_done, i2c_ack
  );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: one-cycle qtick every DIV clocks and a rolling 2-bit phase.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int DIV = 50
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     restart,
  output logic     qtick,
  output q_phase_t phase
);

  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  q_phase_t         phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      phase_reg <= Q0;
    end else if (restart) begin
      cnt_reg   <= '0;
      phase_reg <= Q0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg   <= '0;
      phase_reg <= q_phase_t'(phase_reg + 2'd1);
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign qtick = !restart && (cnt_reg == CNT_LAST);
  assign phase = phase_reg;

endmodule

// File: rtl/i2c_dri.sv
// Single-register write / random-read I2C master with open-drain SDA and push-pull SCL.
module i2c_dri
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h51,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         I2C_FREQ   = 250_000,
  parameter bit         BIT_CTRL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  i2c_dri_if.slave   bus,
  output logic       scl,
  inout  wire        sda
);

  localparam int DIV = div_calc(CLK_FREQ, I2C_FREQ);

  generate
    if (DIV < 2) begin : g_div_check
      $error("i2c_dri: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end
  endgenerate

  i2c_state_t  state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic        rh_wl_reg;
  logic [15:0] addr_reg;
  logic [7:0]  data_w_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  data_r_reg;
  logic        done_reg;
  logic        ack_reg;
  logic        scl_reg, scl_next;
  logic        sda_low_reg, sda_low_next;
  logic [1:0]  sda_sync_reg;
  logic [7:0]  tx_byte;

  logic        qtick;
  q_phase_t    phase;

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state_reg == IDLE),
    .qtick   (qtick),
    .phase   (phase)
  );

  wire capture   = (state_reg == IDLE) && bus.i2c_exec;
  wire bit_end   = qtick && (phase == Q3);
  wire sample    = qtick && (phase == Q2);
  wire sda_in    = sda_sync_reg[1];
  wire write_dir = (state_reg inside {SLA_W, ADDR_H, ADDR_L, WR_DATA, SLA_R});
  wire byte_st   = write_dir || (state_reg == RD_DATA);

  always_comb begin
    tx_byte = addr_reg[7:0];
    case (state_reg)
      SLA_W:   tx_byte = {SLAVE_ADDR, 1'b0};
      ADDR_H:  tx_byte = addr_reg[15:8];
      WR_DATA: tx_byte = data_w_reg;
      SLA_R:   tx_byte = {SLAVE_ADDR, 1'b1};
      default: ;
    endcase
  end

  // ack_reg can only be set by the ACK slot of the byte just finished, so it doubles as the abort flag.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE:    if (bus.i2c_exec) state_next = START;
      START:   if (bit_end) state_next = SLA_W;
      RESTART: if (bit_end) state_next = SLA_R;
      STOP:    if (bit_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: begin
        if (bit_end) begin
          if (bit_cnt_reg == 4'd8) begin
            bit_cnt_next = 4'd0;
            if (ack_reg) begin
              state_next = STOP;
            end else begin
              case (state_reg)
                SLA_W:   state_next = BIT_CTRL ? ADDR_H : ADDR_L;
                ADDR_H:  state_next = ADDR_L;
                ADDR_L:  state_next = rh_wl_reg ? RESTART : WR_DATA;
                SLA_R:   state_next = RD_DATA;
                default: state_next = STOP;
              endcase
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    scl_next     = 1'b1;
    sda_low_next = 1'b0;
    if (state_reg == START || state_reg == RESTART) begin
      scl_next     = (phase != Q3);
      sda_low_next = (phase == Q2) || (phase == Q3);
    end else if (state_reg == STOP) begin
      scl_next     = (phase != Q0);
      sda_low_next = (phase == Q0) || (phase == Q1);
    end else if (byte_st) begin
      scl_next = (phase == Q1) || (phase == Q2);
      if (write_dir && bit_cnt_reg < 4'd8)
        sda_low_next = !tx_byte[3'd7 - bit_cnt_reg[2:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      rh_wl_reg    <= 1'b0;
      addr_reg     <= 16'h0000;
      data_w_reg   <= 8'h00;
      rx_reg       <= 8'h00;
      data_r_reg   <= 8'h00;
      done_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      scl_reg      <= 1'b1;
      sda_low_reg  <= 1'b0;
      sda_sync_reg <= 2'b11;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      scl_reg      <= scl_next;
      sda_low_reg  <= sda_low_next;
      sda_sync_reg <= {sda_sync_reg[0], sda};
      done_reg     <= (state_next == DONE);
      if (capture) begin
        rh_wl_reg  <= bus.i2c_rh_wl;
        addr_reg   <= bus.i2c_addr;
        data_w_reg <= bus.i2c_data_w;
        ack_reg    <= 1'b0;
      end else if (sample && write_dir && bit_cnt_reg == 4'd8 && sda_in) begin
        ack_reg <= 1'b1;
      end
      if (sample && state_reg == RD_DATA && bit_cnt_reg < 4'd8)
        rx_reg <= {rx_reg[6:0], sda_in};
      if (state_next == DONE && rh_wl_reg && !ack_reg)
        data_r_reg <= rx_reg;
    end
  end

  assign scl            = scl_reg;
  assign sda            = sda_low_reg ? 1'b0 : 1'bz;
  assign bus.i2c_done   = done_reg;
  assign bus.i2c_ack    = ack_reg;
  assign bus.i2c_data_r = data_r_reg;

endmodule

// File: tb/tb_i2c_dri.sv
// Bench for i2c_dri: two instances (BIT_CTRL 0 and 1), a bus-level slave model per instance and a transaction model.
`timescale 1ns/1ps
module tb_i2c_dri;

  localparam int DIV = 50;
  localparam int NI  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        exec_a [NI];
  logic        rw_a   [NI];
  logic [15:0] addr_a [NI];
  logic [7:0]  dw_a   [NI];
  logic [7:0]  dr_a   [NI];
  logic        done_a [NI];
  logic        ack_a  [NI];
  logic        scl_a  [NI];
  logic        sda_a  [NI];

  int          nack_at  [NI];
  logic [7:0]  txd      [NI];
  int          tok_q    [NI][$];
  int          done_cnt [NI];
  logic [7:0]  exp_dr   [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    i2c_dri_if bus ();
    wire  sda;
    logic scl;
    logic slave_low;
    logic pc, ps, addr_ph, tx, last_ack;
    logic [7:0] sh;
    int   bit_n, rxcnt;

    assign bus.i2c_exec   = exec_a[gi];
    assign bus.i2c_rh_wl  = rw_a[gi];
    assign bus.i2c_addr   = addr_a[gi];
    assign bus.i2c_data_w = dw_a[gi];
    assign dr_a[gi]       = bus.i2c_data_r;
    assign done_a[gi]     = bus.i2c_done;
    assign ack_a[gi]      = bus.i2c_ack;
    assign scl_a[gi]      = scl;
    assign sda_a[gi]      = sda;
    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_dri #(.BIT_CTRL(gi == 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .scl   (scl),
      .sda   (sda)
    );

    always @(negedge clk) begin
      if (done_a[gi]) done_cnt[gi] <= done_cnt[gi] + 1;
    end

    // Slave: tokens -1 = START, -2 = STOP, else {ack_bit, byte}.
    always @(negedge clk) begin
      if (!rst_n) begin
        slave_low <= 1'b0; bit_n <= 0; addr_ph <= 1'b0; tx <= 1'b0;
        rxcnt <= 0; pc <= 1'b1; ps <= 1'b1; sh <= 8'h00; last_ack <= 1'b1;
      end else begin
        pc <= scl;
        ps <= sda;
        if (scl && pc && ps && !sda) begin
          tok_q[gi].push_back(-1);
          bit_n <= 0; addr_ph <= 1'b1; tx <= 1'b0; slave_low <= 1'b0;
        end else if (scl && pc && !ps && sda) begin
          tok_q[gi].push_back(-2);
          bit_n <= 0; addr_ph <= 1'b0; tx <= 1'b0; slave_low <= 1'b0; rxcnt <= 0;
        end else if (scl && !pc) begin
          if (bit_n < 8) begin
            sh    <= {sh[6:0], sda};
            bit_n <= bit_n + 1;
          end else begin
            tok_q[gi].push_back(int'({sda, sh}));
            last_ack <= sda;
            bit_n    <= 9;
          end
        end else if (!scl && pc) begin
          if (bit_n == 8) begin
            if (tx) slave_low <= 1'b0;
            else begin
              slave_low <= (rxcnt != nack_at[gi]);
              rxcnt     <= rxcnt + 1;
            end
          end else if (bit_n == 9) begin
            bit_n <= 0;
            if (addr_ph) begin
              addr_ph   <= 1'b0;
              tx        <= sh[0] & ~last_ack;
              slave_low <= sh[0] & ~last_ack & ~txd[gi][7];
            end else begin
              tx        <= tx & ~last_ack;
              slave_low <= tx & ~last_ack & ~txd[gi][7];
            end
          end else if (tx && bit_n > 0) begin
            slave_low <= ~txd[gi][3'(7 - bit_n)];
          end
        end
      end
    end
  end

  task automatic run_cmd(input int inst, input bit rw, input logic [15:0] addr,
                         input logic [7:0] dw, input int nack_k, input logic [7:0] rdata,
                         input bit mid_pulse);
    int  seq[$];
    int  exp_tok[$];
    int  n_bits, k, base, start, lat, n_new;
    bit  exp_nack, got_done;

    // Reference: bytes the master sends (-1 marks the repeated START), slave NACKs byte nack_k.
    seq = '{};
    seq.push_back(32'hA2);
    if (inst == 1) seq.push_back(int'(addr[15:8]));
    seq.push_back(int'(addr[7:0]));
    if (rw) begin seq.push_back(-1); seq.push_back(32'hA3); end
    else    seq.push_back(int'(dw));
    exp_tok = '{-1};
    n_bits = 1; exp_nack = 1'b0; k = 0;
    foreach (seq[j]) begin
      if (!exp_nack) begin
        if (seq[j] < 0) begin
          exp_tok.push_back(-1); n_bits += 1;
        end else begin
          n_bits += 9;
          if (k == nack_k) begin exp_nack = 1'b1; exp_tok.push_back(256 + seq[j]); end
          else exp_tok.push_back(seq[j]);
          k++;
        end
      end
    end
    if (rw && !exp_nack) begin
      exp_tok.push_back(256 + int'(rdata)); n_bits += 9; exp_dr[inst] = rdata;
    end
    exp_tok.push_back(-2); n_bits += 1;

    nack_at[inst] = nack_k;
    txd[inst]     = rdata;
    base          = tok_q[inst].size();

    @(negedge clk);
    exec_a[inst] = 1'b1; rw_a[inst] = rw; addr_a[inst] = addr; dw_a[inst] = dw;
    start = cyc;
    @(negedge clk);
    exec_a[inst] = 1'b0;
    rw_a[inst] = 1'($urandom); addr_a[inst] = 16'($urandom); dw_a[inst] = 8'($urandom);
    got_done = 1'b0; lat = 0;
    for (int i = 0; i < 20000 && !got_done; i++) begin
      if (done_a[inst]) begin
        got_done = 1'b1; lat = cyc - start;
      end else begin
        exec_a[inst] = (mid_pulse && i == 300);
        @(negedge clk);
      end
    end
    exec_a[inst] = 1'b0;
    $display("txn inst=%0d rw=%0d addr=%04h dw=%02h nack_k=%0d rdata=%02h -> done=%0d lat=%0d ack=%0d data_r=%02h",
             inst, rw, addr, dw, nack_k, rdata, got_done, lat, ack_a[inst], dr_a[inst]);
    check("done_seen", 32'(got_done), 32'd1);
    check("done_cycle", lat, 4 * DIV * n_bits + 1);
    check("ack", 32'(ack_a[inst]), 32'(exp_nack));
    check("data_r", 32'(dr_a[inst]), 32'(exp_dr[inst]));
    n_new = tok_q[inst].size() - base;
    check("bus_tokens", n_new, exp_tok.size());
    foreach (exp_tok[j]) begin
      if (j < n_new) check($sformatf("bus_tok%0d", j), tok_q[inst][base + j], exp_tok[j]);
    end
    @(negedge clk);
    check("done_pulse_width", 32'(done_a[inst]), 32'd0);
  endtask

  initial begin
    int d0, inst, nk;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      exec_a[i] = 1'b0; rw_a[i] = 1'b0; addr_a[i] = 16'h0; dw_a[i] = 8'h0;
      nack_at[i] = -1; txd[i] = 8'h00; done_cnt[i] = 0; exp_dr[i] = 8'h00;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_scl", 32'(scl_a[i]), 32'd1);
      check("rst_sda", 32'(sda_a[i]), 32'd1);
      check("rst_done", 32'(done_a[i]), 32'd0);
      check("rst_ack", 32'(ack_a[i]), 32'd0);
      check("rst_data_r", 32'(dr_a[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_cmd(0, 1'b0, 16'h0002, 8'h30, -1, 8'h00, 1'b0);
    run_cmd(0, 1'b1, 16'h0004, 8'h00, -1, 8'h09, 1'b0);
    run_cmd(0, 1'b0, 16'h0003, 8'h44, 0, 8'h00, 1'b0);
    run_cmd(1, 1'b0, 16'h1234, 8'h5A, -1, 8'h00, 1'b0);

    // Ignored mid-transaction strobe, then a second command three cycles after done.
    d0 = done_cnt[0];
    run_cmd(0, 1'b0, 16'h0007, 8'hC3, -1, 8'h00, 1'b1);
    @(negedge clk);
    run_cmd(0, 1'b0, 16'h0008, 8'h3C, -1, 8'h00, 1'b0);
    @(negedge clk);
    check("done_count", done_cnt[0] - d0, 2);

    // Reset in the middle of SLA_R.
    nack_at[0] = -1; txd[0] = 8'h77;
    d0 = done_cnt[0];
    @(negedge clk);
    exec_a[0] = 1'b1; rw_a[0] = 1'b1; addr_a[0] = 16'h0005;
    @(negedge clk);
    exec_a[0] = 1'b0;
    repeat (4 * DIV * 22) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset mid-read: scl=%0d sda=%0d done=%0d data_r=%02h", scl_a[0], sda_a[0], done_a[0], dr_a[0]);
    check("midrst_scl", 32'(scl_a[0]), 32'd1);
    check("midrst_sda", 32'(sda_a[0]), 32'd1);
    check("midrst_done", 32'(done_a[0]), 32'd0);
    check("midrst_data_r", 32'(dr_a[0]), 32'd0);
    for (int i = 0; i < NI; i++) exp_dr[i] = 8'h00;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("midrst_no_done", done_cnt[0] - d0, 0);
    run_cmd(0, 1'b0, 16'h000A, 8'h81, -1, 8'h00, 1'b0);

    for (int t = 0; t < 3; t++) begin
      inst = int'($urandom_range(0, 1));
      nk   = int'($urandom_range(0, 5)) - 2;
      run_cmd(inst, 1'($urandom), 16'($urandom), 8'($urandom), nk, 8'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
